// File: rtl/gemm_tile_controller.sv
// Tile sequencer for the GEMM datapath: walks output tiles (m,n) row-major,
// streams K operand reads per tile, drains the mesh, then writes the tile to SRAM C.
module gemm_tile_controller #(
    parameter int AddrWidth     = 12,
    parameter int SizeAddrWidth = 8,
    parameter int MemLatency    = 1,
    parameter int MeshLatency   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     mesh_valid_o,
    output logic                     mesh_clear_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int DrainCycles = MemLatency + MeshLatency;
    localparam int DrainWidth  = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;
    // Wide enough for any size product plus offset, so truncation happens only at the output.
    localparam int ProdWidth   = 2 * SizeAddrWidth + AddrWidth + 1;

    localparam logic [DrainWidth-1:0]    DrainLast = DrainWidth'(DrainCycles - 1);
    localparam logic [DrainWidth-1:0]    DrainOne  = DrainWidth'(1);
    localparam logic [SizeAddrWidth-1:0] SizeOne   = SizeAddrWidth'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [SizeAddrWidth-1:0] m_size_q, k_size_q, n_size_q;
    logic [SizeAddrWidth-1:0] m_q, n_q, k_q;
    logic [DrainWidth-1:0]    drain_q;
    logic [MemLatency-1:0]    valid_pipe_q;
    logic [MemLatency-1:0]    clear_pipe_q;

    logic sizes_nonzero;
    logic k_last;
    logic n_last;
    logic tile_last;
    logic issue;
    logic issue_first;

    assign sizes_nonzero = (M_size_i != '0) && (K_size_i != '0) && (N_size_i != '0);
    assign k_last        = (k_q == k_size_q - SizeOne);
    assign n_last        = (n_q == n_size_q - SizeOne);
    assign tile_last     = n_last && (m_q == m_size_q - SizeOne);
    assign issue         = (state_q == S_FETCH);
    assign issue_first   = issue && (k_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = sizes_nonzero ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (k_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_q == DrainLast) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = tile_last ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sizes are captured only on acceptance so mid-run input changes cannot disturb the walk.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_size_q <= '0;
            k_size_q <= '0;
            n_size_q <= '0;
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            drain_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        m_size_q <= M_size_i;
                        k_size_q <= K_size_i;
                        n_size_q <= N_size_i;
                        m_q      <= '0;
                        n_q      <= '0;
                        k_q      <= '0;
                    end
                end
                S_FETCH: begin
                    k_q     <= k_last ? '0 : k_q + SizeOne;
                    drain_q <= '0;
                end
                S_DRAIN: begin
                    drain_q <= drain_q + DrainOne;
                end
                S_WRITE: begin
                    if (n_last) begin
                        n_q <= '0;
                        m_q <= m_q + SizeOne;
                    end else begin
                        n_q <= n_q + SizeOne;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Operand-valid and first-k flags travel alongside the SRAM read latency.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_pipe_q <= '0;
            clear_pipe_q <= '0;
        end else begin
            valid_pipe_q[0] <= issue;
            clear_pipe_q[0] <= issue_first;
            for (int i = 1; i < MemLatency; i++) begin
                valid_pipe_q[i] <= valid_pipe_q[i-1];
                clear_pipe_q[i] <= clear_pipe_q[i-1];
            end
        end
    end

    always_comb begin
        sram_a_addr_o = '0;
        sram_b_addr_o = '0;
        sram_c_addr_o = '0;
        sram_c_we_o   = 1'b0;
        done_o        = 1'b0;
        busy_o        = (state_q != S_IDLE);
        mesh_valid_o  = valid_pipe_q[MemLatency-1];
        mesh_clear_o  = clear_pipe_q[MemLatency-1] && valid_pipe_q[MemLatency-1];
        unique case (state_q)
            S_FETCH: begin
                sram_a_addr_o = AddrWidth'(ProdWidth'(m_q) * ProdWidth'(k_size_q) + ProdWidth'(k_q));
                sram_b_addr_o = AddrWidth'(ProdWidth'(n_q) * ProdWidth'(k_size_q) + ProdWidth'(k_q));
            end
            S_WRITE: begin
                sram_c_we_o   = 1'b1;
                sram_c_addr_o = AddrWidth'(ProdWidth'(m_q) * ProdWidth'(n_size_q) + ProdWidth'(n_q));
            end
            S_DONE: begin
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/gemm_tile_controller.md
Name: gemm_tile_controller

Overview:
Sequencing controller for the GEMM accelerator datapath. It takes block counts M, K and N and walks every output tile (m,n). For each tile it streams K operand-block reads from SRAM A and SRAM B into the meshRow x meshCol PE mesh, drains the pipeline, then issues one wide write of the accumulated tile to SRAM C. It sits inside gemm_accelerator_top, between the start/size interface and the SRAMs plus mesh.

Parameters:
AddrWidth, 12, SRAM address width (DataDepth 4096).
SizeAddrWidth, 8, width of the M/K/N block-count inputs.
MemLatency, 1, SRAM read latency in cycles (address to rdata).
MeshLatency, 1, cycles from the last mesh_valid_o until the mesh accumulators hold the final tile result.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  start request, sampled only in IDLE
M_size_i  in  SizeAddrWidth  output row-block count
K_size_i  in  SizeAddrWidth  reduction block count
N_size_i  in  SizeAddrWidth  output column-block count
sram_a_addr_o  out  AddrWidth  SRAM A read address
sram_b_addr_o  out  AddrWidth  SRAM B read address
sram_c_addr_o  out  AddrWidth  SRAM C write address
sram_c_we_o  out  1  SRAM C write enable
mesh_valid_o  out  1  SRAM A/B rdata is a valid operand pair this cycle
mesh_clear_o  out  1  mesh accumulators load instead of accumulate (first k of a tile)
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; counters m, n, k = 0; valid/clear delay pipes cleared.
- Latching: sizes are latched when start_i is accepted. Later input changes are ignored until the next IDLE.
- IDLE: start_i=1 with M, K, N all nonzero -> FETCH with m=n=k=0. start_i=1 with any size 0 -> DONE directly; no SRAM access, no C write.
- FETCH: one read per cycle.
  - sram_a_addr_o = m*K+k; sram_b_addr_o = n*K+k.
  - k increments each cycle.
  - On the cycle k==K-1 is issued, next state is DRAIN.
- Operand pipes:
  - A MemLatency-deep pipe delays "read issued" to produce mesh_valid_o.
  - A parallel pipe carries (k==0) to produce mesh_clear_o.
  - mesh_clear_o is only ever high together with mesh_valid_o.
- DRAIN: counter of D = MemLatency+MeshLatency cycles; SRAM A/B addresses driven 0. Then WRITE.
- WRITE: exactly one cycle.
  - sram_c_we_o=1, sram_c_addr_o = m*N+n.
  - Then n increments. On n==N-1, n wraps to 0 and m increments.
  - If (m,n) was (M-1,N-1), next state is DONE; else FETCH with k=0.
- DONE: done_o=1 for one cycle, then IDLE.
- Output values outside their active state: sram_c_addr_o and sram_c_we_o are 0 outside WRITE. SRAM A/B addresses are 0 outside FETCH.
- Arithmetic: products computed at full width, then truncated modulo 2^AddrWidth. The caller guarantees M*K, N*K and M*N are at most 2^AddrWidth.
- Timing, taking the start_i acceptance edge as cycle 0:
  - Per-tile duration is K+D+1 cycles.
  - The last WRITE occurs at cycle M*N*(K+D+1).
  - done_o is high at cycle M*N*(K+D+1)+1.
- Ordering: tiles are processed row-major (n fastest). k order is ascending.
- Boundary conditions:
  - start_i while busy_o=1: ignored, no restart.
  - start_i held high across DONE: re-accepted in IDLE the cycle after done_o.
  - Reset mid-operation: immediate return to reset values. Any in-flight tile is abandoned and no C write occurs.
  - K=1: mesh_valid_o and mesh_clear_o are high in the same single cycle.

Test Plan:
- M=1,K=16,N=4, D=2 -> A addr 0..15 repeated 4 times; B addr n*16+k; C writes at addr 0,1,2,3 on cycles 19,38,57,76; done_o at cycle 77; C contents match the golden 4x64*64x16.
- M=1,K=1,N=1 -> A=B=0 at cycle 1; mesh_valid_o=mesh_clear_o=1 at cycle 2; we at cycle 4 with addr 0; done_o at cycle 5.
- M=4,K=16,N=1 and M=8,K=8,N=8 -> C address sequence 0..M*N-1, exactly M*N we pulses; mesh_clear_o count equals M*N; mesh_valid_o count equals M*N*K; golden compare passes.
- K_size_i=0 (M=N=2) -> done_o one cycle after start, busy_o one cycle, zero we pulses, zero mesh_valid_o.
- start_i pulsed again mid-run, with sizes changed to 3 -> ignored; original sequence and done timing unchanged.
- rst_ni low during the second tile of M=1,K=16,N=4 -> all outputs 0 asynchronously, no C write at addr 1; after release, a fresh start runs a complete, correct sequence.
